// File: rtl/bitonic_sort_ctrl_pkg.sv
// rtl/bitonic_sort_ctrl_pkg.sv - shared types and stage-schedule helpers for the bitonic sort controller
package bitonic_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Largest supported log2(N); bounds the schedule loops below.
  localparam int MAX_LOG2N = 6;

  // Number of (k,j) compare-exchange passes for a full bitonic sort.
  function automatic int stages(input int log2n);
    return log2n * (log2n + 1) / 2;
  endfunction

  // Walks the schedule kexp=1..log2n, jexp=kexp-1..0 and returns kexp at position idx.
  function automatic int stage_k_exp(input int log2n, input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int k = 1; k <= MAX_LOG2N; k++) begin
      for (int j = MAX_LOG2N - 1; j >= 0; j--) begin
        if (k <= log2n && j < k) begin
          if (cnt == idx) res = k;
          cnt++;
        end
      end
    end
    return res;
  endfunction

  // Same walk as stage_k_exp, returning jexp at position idx.
  function automatic int stage_j_exp(input int log2n, input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int k = 1; k <= MAX_LOG2N; k++) begin
      for (int j = MAX_LOG2N - 1; j >= 0; j--) begin
        if (k <= log2n && j < k) begin
          if (cnt == idx) res = j;
          cnt++;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bitonic_sort_ctrl_if.sv
// rtl/bitonic_sort_ctrl_if.sv - input and output word streams of the bitonic sort controller
interface bitonic_sort_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  // Controller side: consumes the input stream, produces the sorted stream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Producer/consumer side around the controller.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/bitonic_stage_net.sv
// rtl/bitonic_stage_net.sv - one combinational compare-exchange pass over N words for a given (k,j)
module bitonic_stage_net #(
  parameter int WIDTH = 8,
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic [WIDTH-1:0] din  [N],
  input  logic [LOG2N:0]   k,
  input  logic [LOG2N-1:0] j,
  output logic [WIDTH-1:0] dout [N]
);

  // Each word looks at its partner i^j. Both share the k bit (k > j), so the
  // direction is the same from either side: the lower index keeps the min for
  // an ascending pair and the max for a descending one. Equal values leave
  // the pair unchanged because min and max coincide.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    logic [LOG2N-1:0] me;
    logic [LOG2N-1:0] partner;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] min_v;
    logic [WIDTH-1:0] max_v;
    logic             asc;
    logic             lower;

    assign me      = LOG2N'(gi);
    assign partner = me ^ j;
    assign a       = din[gi];
    assign b       = din[partner];
    assign min_v   = (a <= b) ? a : b;
    assign max_v   = (a <= b) ? b : a;
    assign asc     = (({1'b0, me} & k) == '0);
    assign lower   = ((me & j) == '0);
    assign dout[gi] = (lower == asc) ? min_v : max_v;
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// rtl/bitonic_sort_ctrl.sv - load N words, run the bitonic schedule one stage per clock, stream out sorted
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  bitonic_sort_ctrl_if.slave s,
  output logic               busy,
  output logic               done
);

  localparam int STAGES = stages(LOG2N);
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [LOG2N-1:0] IDX_LAST   = LOG2N'(N - 1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(STAGES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] rd_idx;
  logic [SW-1:0]    stage_idx;
  logic [WIDTH-1:0] mem     [N];
  logic [WIDTH-1:0] net_out [N];
  logic [LOG2N:0]   k_val;
  logic [LOG2N-1:0] j_val;

  // Decode the current stage index into the network's k and j strides.
  always_comb begin
    k_val = (LOG2N + 1)'(1) << stage_k_exp(LOG2N, int'(stage_idx));
    j_val = LOG2N'(1) << stage_j_exp(LOG2N, int'(stage_idx));
  end

  bitonic_stage_net #(
    .WIDTH (WIDTH),
    .N     (N),
    .LOG2N (LOG2N)
  ) u_net (
    .din  (mem),
    .k    (k_val),
    .j    (j_val),
    .dout (net_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (s.in_valid && wr_idx == IDX_LAST) state_nxt = SORT;
        SORT:    if (stage_idx == STAGE_LAST) state_nxt = DRAIN;
        DRAIN:   if (s.out_ready && rd_idx == IDX_LAST) state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Outputs are decoded from state so reset takes them to idle immediately.
  always_comb begin
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    s.out_data  = '0;
    s.out_last  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      LOAD: s.in_ready = 1'b1;
      SORT: busy = 1'b1;
      DRAIN: begin
        s.out_valid = 1'b1;
        s.out_data  = mem[rd_idx];
        s.out_last  = (rd_idx == IDX_LAST);
        busy        = 1'b1;
        done        = s.out_ready && (rd_idx == IDX_LAST) && !flush;
      end
      default: s.in_ready = 1'b0;
    endcase
  end

  // Indices and register file: capture in LOAD, one network pass per SORT
  // cycle, read pointer advance in DRAIN. Indices wrap naturally at N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      stage_idx <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      stage_idx <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (s.in_valid) begin
            mem[wr_idx] <= s.in_data;
            wr_idx      <= wr_idx + 1'b1;
          end
        end
        SORT: begin
          mem       <= net_out;
          stage_idx <= (stage_idx == STAGE_LAST) ? '0 : stage_idx + 1'b1;
        end
        DRAIN: begin
          if (s.out_ready) rd_idx <= rd_idx + 1'b1;
        end
        default: stage_idx <= '0;
      endcase
    end
  end

endmodule
